sonar_range_filter: RTL and testbench



---
 rtl/sonar_range_filter_if.sv | 27 ++
 rtl/sonar_range_filter.sv | 174 +++++++++++++++++
 tb/tb_sonar_range_filter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sonar_range_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : sonar_range_filter_if
// Brief    : Sample-in / distance-out signal bundle for sonar_range_filter.
// Revision : 1.0
// ============================================================================
interface sonar_range_filter_if;
  logic        in_valid;
  logic [23:0] in_width;
  logic        in_timeout;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_distance;
  logic        out_near;
  logic [7:0]  drop_cnt;

  modport master (
    output in_valid, in_width, in_timeout,
    input  in_ready, out_valid, out_distance, out_near, drop_cnt
  );

  modport slave (
    input  in_valid, in_width, in_timeout,
    output in_ready, out_valid, out_distance, out_near, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sonar_range_filter.sv
`default_nettype none
// ============================================================================
// Module   : sonar_range_filter
// Brief    : Echo width -> cm via 24-step restoring divide, clamp, optional
//            4-sample moving average (SONAR_RANGE_FILTER_AVG_EN), near flag.
// Revision : 1.0
// ============================================================================
module sonar_range_filter #(
  parameter int CYCLES_PER_CM = 2900,
  parameter int MAX_CM        = 400,
  parameter int NEAR_CM       = 30,
  parameter int HYST_CM       = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sonar_range_filter_if.slave  bus
);
  localparam int C_W_W   = 24;
  localparam int C_R_W   = $clog2(CYCLES_PER_CM);
  localparam int C_Q_W   = $clog2(MAX_CM + 1);
  localparam logic [C_R_W:0]   C_DIVISOR  = (C_R_W + 1)'(CYCLES_PER_CM);
  localparam logic [C_W_W-1:0] C_MAX_W    = C_W_W'(MAX_CM);
  localparam logic [C_Q_W-1:0] C_MAX_Q    = C_Q_W'(MAX_CM);
  localparam logic [C_Q_W-1:0] C_NEAR_SET = C_Q_W'(NEAR_CM);
  localparam logic [C_Q_W-1:0] C_NEAR_CLR = C_Q_W'(NEAR_CM + HYST_CM);
  localparam logic [4:0]       C_LAST_IT  = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIV    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [C_W_W-1:0]   dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [C_R_W-1:0]   rem_q, rem_d;
  logic               tmo_q, tmo_d;
  logic [C_Q_W-1:0]   dist_q, dist_d;
  logic               near_q, near_d;
  logic               valid_q, valid_d;
  logic [7:0]         drop_q, drop_d;

  logic [C_R_W:0]     w_rem_sh;
  logic               w_ge;
  logic [C_Q_W-1:0]   w_q;
  logic [C_Q_W-1:0]   w_new;

  always_comb begin
    w_rem_sh = {rem_q, dvd_q[C_W_W-1]};
    w_ge     = (w_rem_sh >= C_DIVISOR);
    if (tmo_q || (dvd_q >= C_MAX_W)) begin
      w_q = C_MAX_Q;
    end else begin
      w_q = dvd_q[C_Q_W-1:0];
    end
  end

`ifdef SONAR_RANGE_FILTER_AVG_EN
  // Three previous samples; together with the incoming one they form the 4-entry window.
  logic [C_Q_W-1:0]   hist_q [3];
  logic [C_Q_W-1:0]   hist_d [3];
  logic               first_q, first_d;
  logic [C_Q_W+1:0]   w_sum;

  always_comb begin
    if (first_q) begin
      w_sum = {w_q, 2'b00};
    end else begin
      w_sum = (C_Q_W + 2)'(w_q) + (C_Q_W + 2)'(hist_q[0])
            + (C_Q_W + 2)'(hist_q[1]) + (C_Q_W + 2)'(hist_q[2]);
    end
    w_new = C_Q_W'(w_sum >> 2);
  end
`else
  assign w_new = w_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    dist_d  = dist_q;
    near_d  = near_q;
    valid_d = 1'b0;
    drop_d  = drop_q;
`ifdef SONAR_RANGE_FILTER_AVG_EN
    hist_d  = hist_q;
    first_d = first_q;
`endif
    if (bus.in_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.in_width;
          tmo_d   = bus.in_timeout;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = C_R_W'(w_ge ? (w_rem_sh - C_DIVISOR) : w_rem_sh);
        dvd_d = {dvd_q[C_W_W-2:0], w_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_IT) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        dist_d = w_new;
        if (w_new < C_NEAR_SET) begin
          near_d = 1'b1;
        end else if (w_new >= C_NEAR_CLR) begin
          near_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
`ifdef SONAR_RANGE_FILTER_AVG_EN
        if (first_q) begin
          hist_d = '{w_q, w_q, w_q};
        end else begin
          hist_d = '{w_q, hist_q[0], hist_q[1]};
        end
        first_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= 1'b0;
      dist_q  <= '0;
      near_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
`ifdef SONAR_RANGE_FILTER_AVG_EN
      hist_q  <= '{default: '0};
      first_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      dist_q  <= dist_d;
      near_q  <= near_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
`ifdef SONAR_RANGE_FILTER_AVG_EN
      hist_q  <= hist_d;
      first_q <= first_d;
`endif
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.out_valid    = valid_q;
  assign bus.out_distance = 16'(dist_q);
  assign bus.out_near     = near_q;
  assign bus.drop_cnt     = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_sonar_range_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_range_filter
// Brief    : Random + directed stimulus against a behavioural range model.
// Revision : 1.0
// ============================================================================
module tb_sonar_range_filter;
  localparam int CPC   = 2900;
  localparam int MAXC  = 400;
  localparam int NEARC = 30;
  localparam int HYSTC = 5;
  localparam int LAT   = 25;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  sonar_range_filter_if tif ();

  sonar_range_filter #(
    .CYCLES_PER_CM (CPC),
    .MAX_CM        (MAXC),
    .NEAR_CM       (NEARC),
    .HYST_CM       (HYSTC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (tif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: cycles left until result, pending sample, filtered state
  int m_left  = 0;
  int m_pend  = 0;
  int m_dist  = 0;
  int m_drop  = 0;
  bit m_near  = 1'b0;
  bit m_valid = 1'b0;
`ifdef SONAR_RANGE_FILTER_AVG_EN
  bit m_first = 1'b1;
  int win[$];
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sample_cm(input int w, input bit t);
    if (t) return MAXC;
    return (w / CPC > MAXC) ? MAXC : w / CPC;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_left  = 0;
      m_dist  = 0;
      m_drop  = 0;
      m_near  = 1'b0;
      m_valid = 1'b0;
`ifdef SONAR_RANGE_FILTER_AVG_EN
      m_first = 1'b1;
      win.delete();
`endif
    end else begin
      m_valid = 1'b0;
      if (m_left == 0) begin
        if (tif.in_valid) begin
          m_pend = sample_cm(int'(tif.in_width), tif.in_timeout);
          m_left = LAT;
        end
      end else begin
        if (tif.in_valid && m_drop < 255) m_drop++;
        m_left--;
        if (m_left == 0) begin
`ifdef SONAR_RANGE_FILTER_AVG_EN
          if (m_first) begin
            win = '{m_pend, m_pend, m_pend, m_pend};
            m_first = 1'b0;
          end else begin
            win.push_front(m_pend);
            void'(win.pop_back());
          end
          m_dist = (win[0] + win[1] + win[2] + win[3]) / 4;
`else
          m_dist = m_pend;
`endif
          if (m_dist < NEARC) m_near = 1'b1;
          else if (m_dist >= NEARC + HYSTC) m_near = 1'b0;
          m_valid = 1'b1;
        end
      end
    end
    #1;
    chk("in_ready",     int'(tif.in_ready),     int'(m_left == 0));
    chk("out_valid",    int'(tif.out_valid),    int'(m_valid));
    chk("out_distance", int'(tif.out_distance), m_dist);
    chk("out_near",     int'(tif.out_near),     int'(m_near));
    chk("drop_cnt",     int'(tif.drop_cnt),     m_drop);
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (m_left != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wait_idle_bound", int'(m_left != 0), 0);
  endtask

  task automatic send(input logic [23:0] w, input bit t);
    wait_idle();
    tif.in_valid   = 1'b1;
    tif.in_width   = w;
    tif.in_timeout = t;
    @(negedge clk);
    tif.in_valid   = 1'b0;
    tif.in_timeout = 1'b0;
  endtask

  // Leaves the bench on the first negedge where the result must be visible
  task automatic send_wait(input logic [23:0] w, input bit t);
    send(w, t);
    repeat (LAT) @(negedge clk);
  endtask

  task automatic send_check(input logic [23:0] w, input bit t, input int d, input int nr);
    send_wait(w, t);
    chk("lit_valid", int'(tif.out_valid),    1);
    chk("lit_dist",  int'(tif.out_distance), d);
    chk("lit_near",  int'(tif.out_near),     nr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready", int'(tif.in_ready),     1);
    chk("rst_valid", int'(tif.out_valid),    0);
    chk("rst_dist",  int'(tif.out_distance), 0);
    chk("rst_near",  int'(tif.out_near),     0);
    chk("rst_drop",  int'(tif.drop_cnt),     0);
  endtask

  function automatic logic [23:0] rand_width();
    int k;
    case ($urandom % 4)
      0: return 24'($urandom_range(0, 130 * CPC));
      1: return 24'($urandom);
      2: begin
        k = int'($urandom_range(1, 401));
        return 24'(k * CPC - int'($urandom % 2));
      end
      default: return 24'($urandom_range(0, 200000));
    endcase
  endfunction

  int hcm[6]  = '{25, 32, 34, 35, 32, 29};
  bit hexp[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    tif.in_valid   = 1'b0;
    tif.in_width   = '0;
    tif.in_timeout = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_reset_outputs();

    // Boundary just below one cm, then the basic pair
    send_check(24'd2899, 1'b0, 0, 1);
    do_reset();
    send_check(24'd29000, 1'b0, 10, 1);
`ifdef SONAR_RANGE_FILTER_AVG_EN
    send_check(24'd58000, 1'b0, 12, 1);
`else
    send_check(24'd58000, 1'b0, 20, 1);
`endif

    // Clamp: quotient 689 becomes 400 per sample
    repeat (3) send_wait(24'd2000000, 1'b0);
    send_check(24'd2000000, 1'b0, 400, 0);
    send_check(24'd12345, 1'b1, 400, 0);

    // Hysteresis walk
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_wait(24'(hcm[i] * CPC + 1000), 1'b0);
`ifndef SONAR_RANGE_FILTER_AVG_EN
      chk("lit_hyst_near", int'(tif.out_near), int'(hexp[i]));
`endif
    end

    // Drops during DIV leave the in-flight result intact
    do_reset();
    wait_idle();
    tif.in_valid = 1'b1;
    tif.in_width = 24'(50 * CPC);
    @(negedge clk);
    tif.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    tif.in_valid = 1'b1;
    tif.in_width = 24'(5 * CPC);
    repeat (3) @(negedge clk);
    tif.in_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("lit_drop_valid", int'(tif.out_valid),    1);
    chk("lit_drop_dist",  int'(tif.out_distance), 50);
    chk("lit_drop_cnt",   int'(tif.drop_cnt),     3);

    // Reset landing on DIV iteration 12 abandons the sample
    wait_idle();
    tif.in_valid = 1'b1;
    tif.in_width = 24'(70 * CPC);
    @(negedge clk);
    tif.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_reset_outputs();
    repeat (30) @(negedge clk);
    send_check(24'(100 * CPC), 1'b0, 100, 0);

    // Drop counter saturation
    do_reset();
    tif.in_valid = 1'b1;
    tif.in_width = 24'd100000;
    repeat (350) @(negedge clk);
    tif.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("lit_drop_sat", int'(tif.drop_cnt), 255);

    // Randomized traffic, including stray timeouts without valid
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (m_left == 0) tif.in_valid = (($urandom % 3) == 0);
      else             tif.in_valid = (($urandom % 20) == 0);
      tif.in_width   = rand_width();
      tif.in_timeout = (($urandom % 6) == 0);
    end
    @(negedge clk);
    tif.in_valid   = 1'b0;
    tif.in_timeout = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
